layer2_mac_sequencer: RTL and testbench
=======================================

// Module: layer2_mac_sequencer
// PURPOSE
// - Sequences the output layer (layer 2) of the MLP: for each output neuron it reads the bias ROM
//   (6-bit address, 16-bit data, async read) and the layer-2 weight ROM, streams hidden activations,
//   and accumulates one MAC per cycle.
// - Emits one signed Q-format score per neuron over a valid/ready stream into the argmax stage.
// - Sits between the hidden-activation buffer and the argmax/classifier logic.
// PARAMETERS
// - N_IN   32  hidden activations per neuron (MAC count)
// - N_OUT  10  output neurons (digit classes); N_OUT <= 64
// - DW     16  data width of activations, weights, bias and output (signed two's complement)
// - FRAC   8   fractional bits (Q8.8)
// - ACCW   40  accumulator width; must be >= 2*DW + clog2(N_IN) + 1
// PORTS
// - clk      in   1       rising-edge clock
// - reset    in   1       synchronous, active-high reset
// - start    in   1       begin one inference; sampled only in IDLE
// - busy     out  1       high from the cycle after start until done
// - done     out  1       one-cycle pulse after the last score handshake
// - x_addr   out  clog2(N_IN)         hidden-activation index
// - x_data   in   DW                   activation (same-cycle, async read)
// - w_addr   out  clog2(N_IN*N_OUT)   weight index = neuron*N_IN + i
// - w_data   in   DW                   weight (same-cycle, async read)
// - b_addr   out  6                    bias index = neuron
// - b_data   in   DW                   bias in Q(DW-FRAC).FRAC (same-cycle, async read)
// - y_valid  out  1       score valid
// - y_ready  in   1       downstream accepts score
// - y_idx    out  clog2(N_OUT)         neuron index of y_data
// - y_data   out  DW                   signed score
// BEHAVIOUR
// - Reset: all state goes to IDLE. busy=0, done=0, y_valid=0, y_idx=0, y_data=0, all addresses=0,
//   acc=0, counters=0. Reset mid-inference aborts with no partial output.
// - FSM:
//   - IDLE -start-> BIAS
//   - BIAS -> MAC
//   - MAC (i = 0..N_IN-1) -i==N_IN-1-> EMIT
//   - EMIT -(y_valid & y_ready) and neuron<N_OUT-1-> BIAS with neuron+1
//   - EMIT -(y_valid & y_ready) and neuron==N_OUT-1-> DONE
//   - DONE -> IDLE
// - BIAS: b_addr=neuron; acc <= sign_extend(b_data) << FRAC.
// - MAC: x_addr=i, w_addr=neuron*N_IN+i; acc <= acc + signed(x_data)*signed(w_data) (full 2*DW product).
// - EMIT: y_data = acc >>> FRAC (arithmetic shift), narrowed to DW; y_idx=neuron; y_valid=1.
//   Hold y_data, y_idx and all addresses stable while y_ready=0. y_valid never drops without a handshake.
// - Latency with y_ready tied high: start at edge 0; first y_valid in cycle N_IN+2; neuron period N_IN+2 cycles;
//   done pulse in cycle N_OUT*(N_IN+2)+1; busy falls together with the done pulse.
// - start is ignored when not in IDLE. start held high re-triggers on the cycle after DONE.
// - y_ready asserted while y_valid=0 has no effect.
// CONFIGURATION
// - ACC_SAT_EN defined: the EMIT narrowing saturates.
//   - Value above 2^(DW-1)-1 gives 16'h7FFF; below -2^(DW-1) gives 16'h8000.
// - ACC_SAT_EN undefined: narrowing truncates (keeps the low DW bits, wrap-around).
// - Accumulation itself never saturates in either build.
// TESTING
// - T1 basic: x all 1.0 (16'h0100), w all 0.5 (16'h0080), bias 0 -> each y_data=16'h1000 (16.0), y_idx 0..9 in order.
// - T2 bias only: w all 0, bias[k]=k*256 -> y_data=k*256. One done pulse at cycle 341 (N_IN=32, N_OUT=10).
// - T3 backpressure: y_ready low 5 cycles at neuron 3 -> y_data, y_idx and w_addr stable, no score lost or duplicated.
// - T4 overflow: x=16'h7FFF, w=16'h7FFF -> 16'h8000-side wrap without ACC_SAT_EN; 16'h7FFF with ACC_SAT_EN.
// - T5 reset mid-run: reset asserted in MAC of neuron 4 -> next cycle IDLE, y_valid=0, busy=0; a new start gives a full correct run.
// - T6 start ignored: start pulses while busy -> exactly N_OUT scores, one done.

Source files
------------

// File: rtl/layer2_mac_sequencer_if.sv
// Score stream from the layer-2 MAC sequencer into the argmax stage.
interface layer2_mac_sequencer_if #(
  parameter int DW   = 16,
  parameter int IDXW = 4
);
  logic            y_valid;
  logic            y_ready;
  logic [IDXW-1:0] y_idx;
  logic [DW-1:0]   y_data;

  modport master (output y_valid, y_idx, y_data, input  y_ready);
  modport slave  (input  y_valid, y_idx, y_data, output y_ready);
endinterface

// File: rtl/layer2_mac_sequencer.sv
// Output-layer MAC sequencer: bias load, N_IN MACs and one score handshake per neuron.
// Build option ACC_SAT_EN: saturate (instead of wrap) when narrowing the accumulator to DW.
module layer2_mac_sequencer #(
  parameter  int N_IN  = 32,
  parameter  int N_OUT = 10,
  parameter  int DW    = 16,
  parameter  int FRAC  = 8,
  parameter  int ACCW  = 40,
  localparam int XAW   = $clog2(N_IN),
  localparam int WAW   = $clog2(N_IN*N_OUT),
  localparam int NW    = $clog2(N_OUT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [XAW-1:0]   x_addr,
  input  logic [DW-1:0]    x_data,
  output logic [WAW-1:0]   w_addr,
  input  logic [DW-1:0]    w_data,
  output logic [5:0]       b_addr,
  input  logic [DW-1:0]    b_data,
  layer2_mac_sequencer_if.master y
);

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_EMIT, S_DONE} state_t;

  state_t                  st, st_nxt;
  logic [XAW-1:0]          i_cnt;
  logic [NW-1:0]           n_cnt;
  logic signed [ACCW-1:0]  acc;
  logic signed [2*DW-1:0]  prod;
  logic                    hs, last_i, last_n;

  assign hs     = y.y_valid & y.y_ready;
  assign last_i = (i_cnt == XAW'(N_IN-1));
  assign last_n = (n_cnt == NW'(N_OUT-1));
  assign prod   = $signed(x_data) * $signed(w_data);

  // Addresses come straight from the counters, so they stay frozen during EMIT.
  assign x_addr  = i_cnt;
  assign w_addr  = WAW'(n_cnt) * WAW'(N_IN) + WAW'(i_cnt);
  assign b_addr  = 6'(n_cnt);
  assign y.y_idx = n_cnt;

`ifdef ACC_SAT_EN
  logic [ACCW-FRAC-DW:0] hi;
  assign hi = acc[ACCW-1:FRAC+DW-1];
  always_comb begin
    if (&hi || ~|hi) y.y_data = acc[FRAC+DW-1:FRAC];
    else if (acc[ACCW-1]) y.y_data = {1'b1, {(DW-1){1'b0}}};
    else y.y_data = {1'b0, {(DW-1){1'b1}}};
  end
`else
  assign y.y_data = acc[FRAC+DW-1:FRAC];
`endif

  always_ff @(posedge clk) begin
    if (reset) st <= S_IDLE;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt    = st;
    busy      = 1'b0;
    done      = 1'b0;
    y.y_valid = 1'b0;
    case (st)
      S_IDLE: if (start) st_nxt = S_BIAS;
      S_BIAS: begin
        busy   = 1'b1;
        st_nxt = S_MAC;
      end
      S_MAC: begin
        busy = 1'b1;
        if (last_i) st_nxt = S_EMIT;
      end
      S_EMIT: begin
        busy      = 1'b1;
        y.y_valid = 1'b1;
        if (hs) st_nxt = last_n ? S_DONE : S_BIAS;
      end
      S_DONE: begin
        done   = 1'b1;
        st_nxt = S_IDLE;
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_cnt <= '0;
      n_cnt <= '0;
      acc   <= '0;
    end else begin
      case (st)
        S_BIAS: acc <= {{(ACCW-DW){b_data[DW-1]}}, b_data} << FRAC;
        S_MAC: begin
          acc <= acc + {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
          if (!last_i) i_cnt <= i_cnt + 1'b1;
        end
        S_EMIT: if (hs) begin
          i_cnt <= '0;
          if (!last_n) n_cnt <= n_cnt + 1'b1;
        end
        S_DONE: begin
          i_cnt <= '0;
          n_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer2_mac_sequencer.sv
// Randomized bench for layer2_mac_sequencer against a dot-product reference model.
module tb_layer2_mac_sequencer;
  localparam int N_IN = 32, N_OUT = 10, DW = 16, XAW = 5, WAW = 9, NW = 4;

  logic           clk = 1'b0;
  logic           reset, start, busy, done;
  logic [XAW-1:0] x_addr;
  logic [WAW-1:0] w_addr;
  logic [5:0]     b_addr;
  logic [DW-1:0]  x_data, w_data, b_data;

  logic [15:0] x_mem [N_IN];
  logic [15:0] w_mem [N_IN*N_OUT];
  logic [15:0] b_mem [64];

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  layer2_mac_sequencer_if #(.DW(DW), .IDXW(NW)) y ();

  layer2_mac_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .x_addr(x_addr), .x_data(x_data), .w_addr(w_addr), .w_data(w_data),
    .b_addr(b_addr), .b_data(b_data), .y(y)
  );

  assign x_data = x_mem[x_addr];
  assign w_data = w_mem[w_addr];
  assign b_data = b_mem[b_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Score = (bias*2^8 + sum x*w) / 2^8, then narrowed to 16 bits.
  function automatic logic [15:0] exp_score(input int n);
    longint s;
    s = longint'($signed(b_mem[n])) * 256;
    for (int i = 0; i < N_IN; i++)
      s += longint'($signed(x_mem[i])) * longint'($signed(w_mem[n*N_IN+i]));
    s = s >>> 8;
`ifdef ACC_SAT_EN
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
`endif
    return s[15:0];
  endfunction

  // mode 0: x=1.0 w=0.5 b=0; 1: w=0 b=k*256; 2: saturating extremes; 3: random
  task automatic fill(input int mode);
    for (int i = 0; i < N_IN; i++)
      x_mem[i] = (mode == 0) ? 16'h0100 : (mode == 2) ? 16'h7FFF : 16'($urandom);
    for (int i = 0; i < N_IN*N_OUT; i++)
      w_mem[i] = (mode == 0) ? 16'h0080 : (mode == 1) ? 16'h0 : (mode == 2) ? 16'h7FFF : 16'($urandom);
    for (int k = 0; k < 64; k++)
      b_mem[k] = (mode == 1) ? 16'(k*256) : (mode == 3) ? 16'($urandom) : 16'h0;
  endtask

  // rmode 0: ready tied high; 1: 5-cycle stall at neuron 3; 2: random ready
  task automatic run(input int rmode, input bit poke, input int rst_cyc, input bit lat);
    int cyc, nsc, ndone, stall, dcyc;
    bit held;
    logic [15:0] hd;
    logic [NW-1:0] hi;
    logic [WAW-1:0] hw;
    nsc = 0; ndone = 0; stall = 0; dcyc = 0; held = 0; cyc = 0;
    @(negedge clk);
    start = 1'b1;
    y.y_ready = (rmode == 0);
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (rst_cyc != 0 && cyc == rst_cyc) begin
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", y.y_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", y.y_idx, 0);
        chk("rst_data", y.y_data, 0);
        chk("rst_waddr", w_addr, 0);
        reset = 1'b0;
        return;
      end
      if (cyc == 1) chk("busy_rise", busy, 1);
      if (held) begin
        chk("hold_valid", y.y_valid, 1);
        chk("hold_data", y.y_data, hd);
        chk("hold_idx", y.y_idx, hi);
        chk("hold_waddr", w_addr, hw);
      end
      case (rmode)
        0: y.y_ready = 1'b1;
        1: begin
          y.y_ready = !(y.y_valid && y.y_idx == 3 && stall < 5);
          if (y.y_valid && y.y_idx == 3 && stall < 5) stall++;
        end
        default: y.y_ready = 1'($urandom_range(0, 1));
      endcase
      held = 1'b0;
      if (y.y_valid) begin
        if (lat && nsc == 0) chk("first_valid_cyc", cyc, N_IN+2);
        if (y.y_ready) begin
          if (nsc < N_OUT) begin
            chk("y_idx", y.y_idx, nsc);
            chk("y_data", y.y_data, exp_score(nsc));
          end else chk("extra_score", nsc, N_OUT-1);
          nsc++;
        end else begin
          held = 1'b1;
          hd = y.y_data; hi = y.y_idx; hw = w_addr;
        end
      end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          dcyc = cyc;
          chk("scores_at_done", nsc, N_OUT);
          chk("busy_at_done", busy, 0);
          if (lat) chk("done_cyc", cyc, N_OUT*(N_IN+2)+1);
        end
      end else if (ndone > 0) chk("idle_after_done", {busy, y.y_valid}, 0);
      start = (poke && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (ndone > 0 && cyc >= dcyc + 3) break;
    end
    start = 1'b0;
    chk("done_count", ndone, 1);
    chk("score_count", nsc, N_OUT);
    if (rmode == 1) chk("stall_cycles", stall, 5);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; y.y_ready = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_valid", y.y_valid, 0);
    chk("reset_idx", y.y_idx, 0);
    chk("reset_data", y.y_data, 0);
    chk("reset_addrs", {x_addr, w_addr, b_addr}, 0);
    reset = 1'b0;
    y.y_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_start", busy, 0);

    fill(0); run(0, 0, 0, 1);   // basic: every score 16.0
    fill(1); run(0, 0, 0, 1);   // bias only, done at cycle 341
    fill(3); run(1, 0, 0, 0);   // backpressure at neuron 3
    fill(2); run(2, 0, 0, 0);   // narrowing overflow
    fill(3); run(0, 0, 150, 0); // reset inside neuron 4 MAC
    fill(3); run(2, 0, 0, 0);   // full run after abort
    fill(3); run(2, 1, 0, 0);   // start pulses while busy
    fill(3); run(0, 1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
